race_progress_tracker: RTL and testbench

Sequential game-state keeper that sits directly upstream of the screen router. It turns rising edges on the four player buttons and a start button into the four 7-bit car positions and the `is_in_menu` flag that the router consumes. It owns the MENU → PLAYING → FINISHED life cycle: saturation at the finish line, winner capture, and the timed return to the menu.

---
 rtl/race_progress_tracker_if.sv | 28 ++
 rtl/race_progress_tracker.sv | 116 +++++++++++
 tb/tb_race_progress_tracker.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/race_progress_tracker_if.sv
// Button inputs and race-state outputs shared between the
// input front end, the tracker and the screen router.
interface race_progress_tracker_if;
  logic       btn_green;
  logic       btn_red;
  logic       btn_blue;
  logic       btn_yellow;
  logic       btn_start;
  logic [6:0] green_cur_pos;
  logic [6:0] red_cur_pos;
  logic [6:0] blue_cur_pos;
  logic [6:0] yellow_cur_pos;
  logic       is_in_menu;
  logic [3:0] joined;
  logic [3:0] winner;

  modport master (
    output btn_green, btn_red, btn_blue, btn_yellow, btn_start,
    input  green_cur_pos, red_cur_pos, blue_cur_pos,
    input  yellow_cur_pos, is_in_menu, joined, winner
  );

  modport slave (
    input  btn_green, btn_red, btn_blue, btn_yellow, btn_start,
    output green_cur_pos, red_cur_pos, blue_cur_pos,
    output yellow_cur_pos, is_in_menu, joined, winner
  );
endinterface

// File: rtl/race_progress_tracker.sv
// Race game state: button edges to car positions, join mask,
// winner capture and the MENU/PLAYING/FINISHED life cycle.
module race_progress_tracker #(
  parameter int MAX_POS        = 109,
  parameter int FINISH_TIMEOUT = 1_000_000,
  parameter int TMR_W          = 20
) (
  input logic                   clk,
  input logic                   rst_n,
  race_progress_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    MENU     = 2'd0,
    PLAYING  = 2'd1,
    FINISHED = 2'd2,
    UNUSED   = 2'd3
  } state_t;

  localparam logic [6:0] MAX = 7'(MAX_POS);
  localparam logic [TMR_W-1:0] T_LAST =
    TMR_W'(FINISH_TIMEOUT - 1);

  state_t           state, state_n;
  logic [3:0]       btn, btn_q, press;
  logic             start_q, start_p;
  logic [3:0]       joined, joined_n;
  logic [3:0]       winner, winner_n;
  logic [3:0]       hit;
  logic [6:0]       pos [4];
  logic [6:0]       pos_n [4];
  logic [TMR_W-1:0] tmr, tmr_n;
  logic             menu_q;

  assign btn = {bus.btn_yellow, bus.btn_blue,
                bus.btn_red, bus.btn_green};
  assign press   = btn & ~btn_q;
  assign start_p = bus.btn_start & ~start_q;

  always_comb begin
    state_n  = state;
    joined_n = joined;
    winner_n = winner;
    tmr_n    = tmr;
    pos_n    = pos;
    hit      = '0;
    case (state)
      MENU: begin
        joined_n = joined | press;
        for (int i = 0; i < 4; i++) pos_n[i] = '0;
        if (start_p && joined != '0) state_n = PLAYING;
      end
      PLAYING: begin
        for (int i = 0; i < 4; i++) begin
          if (press[i] && joined[i] && pos[i] < MAX)
            pos_n[i] = pos[i] + 7'd1;
          hit[i] = (pos_n[i] == MAX);
        end
        if (hit != '0) begin
          state_n  = FINISHED;
          winner_n = hit;
          tmr_n    = '0;
        end
      end
      FINISHED: begin
        tmr_n = tmr + TMR_W'(1);
        if (start_p || tmr == T_LAST) begin
          state_n  = MENU;
          joined_n = '0;
          winner_n = '0;
          tmr_n    = '0;
          for (int i = 0; i < 4; i++) pos_n[i] = '0;
        end
      end
      default: begin
        state_n  = MENU;
        joined_n = '0;
        winner_n = '0;
        tmr_n    = '0;
        for (int i = 0; i < 4; i++) pos_n[i] = '0;
      end
    endcase
  end

  // Edge registers reset high so a button held through reset is not a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= MENU;
      btn_q   <= '1;
      start_q <= 1'b1;
      joined  <= '0;
      winner  <= '0;
      tmr     <= '0;
      menu_q  <= 1'b1;
      for (int i = 0; i < 4; i++) pos[i] <= '0;
    end else begin
      state   <= state_n;
      btn_q   <= btn;
      start_q <= bus.btn_start;
      joined  <= joined_n;
      winner  <= winner_n;
      tmr     <= tmr_n;
      menu_q  <= (state_n == MENU);
      for (int i = 0; i < 4; i++) pos[i] <= pos_n[i];
    end
  end

  assign bus.green_cur_pos  = pos[0];
  assign bus.red_cur_pos    = pos[1];
  assign bus.blue_cur_pos   = pos[2];
  assign bus.yellow_cur_pos = pos[3];
  assign bus.is_in_menu     = menu_q;
  assign bus.joined         = joined;
  assign bus.winner         = winner;

endmodule

// File: tb/tb_race_progress_tracker.sv
// Directed bench for race_progress_tracker: vector table for
// join/play, hand sequences for finish, timeout and reset.
module tb_race_progress_tracker;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  race_progress_tracker_if bus();

  race_progress_tracker #(
    .MAX_POS(45),
    .FINISH_TIMEOUT(8),
    .TMR_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic [3:0] btn;
    logic       start;
    logic [6:0] g;
    logic [6:0] r;
    logic [6:0] b;
    logic       menu;
    logic [3:0] joined;
    logic [3:0] winner;
  } vec_t;

  vec_t tbl [15];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_btn(input logic [3:0] b, input logic s);
    {bus.btn_yellow, bus.btn_blue,
     bus.btn_red, bus.btn_green} = b;
    bus.btn_start = s;
  endtask

  task automatic press(input logic [3:0] b, input logic s);
    set_btn(b, s);
    step();
    set_btn(4'b0000, 1'b0);
    step();
  endtask

  initial begin
    int n;
    errors = 0;
    checks = 0;

    tbl[0]  = '{4'b0000, 1'b0, 7'd0, 7'd0, 7'd0, 1'b1, 4'b0001, 4'b0};
    tbl[1]  = '{4'b0010, 1'b0, 7'd0, 7'd0, 7'd0, 1'b1, 4'b0011, 4'b0};
    tbl[2]  = '{4'b0000, 1'b0, 7'd0, 7'd0, 7'd0, 1'b1, 4'b0011, 4'b0};
    tbl[3]  = '{4'b0000, 1'b1, 7'd0, 7'd0, 7'd0, 1'b0, 4'b0011, 4'b0};
    tbl[4]  = '{4'b0000, 1'b0, 7'd0, 7'd0, 7'd0, 1'b0, 4'b0011, 4'b0};
    tbl[5]  = '{4'b0001, 1'b0, 7'd1, 7'd0, 7'd0, 1'b0, 4'b0011, 4'b0};
    tbl[6]  = '{4'b0000, 1'b0, 7'd1, 7'd0, 7'd0, 1'b0, 4'b0011, 4'b0};
    tbl[7]  = '{4'b0011, 1'b0, 7'd2, 7'd1, 7'd0, 1'b0, 4'b0011, 4'b0};
    tbl[8]  = '{4'b0001, 1'b0, 7'd2, 7'd1, 7'd0, 1'b0, 4'b0011, 4'b0};
    tbl[9]  = '{4'b0000, 1'b0, 7'd2, 7'd1, 7'd0, 1'b0, 4'b0011, 4'b0};
    tbl[10] = '{4'b0101, 1'b0, 7'd3, 7'd1, 7'd0, 1'b0, 4'b0011, 4'b0};
    tbl[11] = '{4'b0000, 1'b0, 7'd3, 7'd1, 7'd0, 1'b0, 4'b0011, 4'b0};
    tbl[12] = '{4'b0100, 1'b0, 7'd3, 7'd1, 7'd0, 1'b0, 4'b0011, 4'b0};
    tbl[13] = '{4'b0000, 1'b1, 7'd3, 7'd1, 7'd0, 1'b0, 4'b0011, 4'b0};
    tbl[14] = '{4'b0000, 1'b0, 7'd3, 7'd1, 7'd0, 1'b0, 4'b0011, 4'b0};

    // Reset with green held high throughout
    rst_n = 1'b0;
    set_btn(4'b0001, 1'b0);
    step();
    step();
    check("rst_menu", 32'(bus.is_in_menu), 32'd1);
    check("rst_winner", 32'(bus.winner), 32'd0);
    check("rst_pos", 32'({bus.green_cur_pos, bus.red_cur_pos,
                          bus.blue_cur_pos, bus.yellow_cur_pos}), 32'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("held_joined", 32'(bus.joined), 32'd0);
    check("held_gpos", 32'(bus.green_cur_pos), 32'd0);
    set_btn(4'b0000, 1'b0);
    step();
    set_btn(4'b0001, 1'b0);
    step();
    check("join_green", 32'(bus.joined), 32'b0001);

    for (int i = 0; i < 15; i++) begin
      set_btn(tbl[i].btn, tbl[i].start);
      step();
      check($sformatf("vec%0d", i),
            32'({bus.green_cur_pos, bus.red_cur_pos,
                 bus.blue_cur_pos, bus.is_in_menu,
                 bus.joined, bus.winner}),
            32'({tbl[i].g, tbl[i].r, tbl[i].b, tbl[i].menu,
                 tbl[i].joined, tbl[i].winner}));
    end
    set_btn(4'b0000, 1'b0);

    // Bring red level with green, then both arrive together
    press(4'b0010, 1'b0);
    press(4'b0010, 1'b0);
    check("red_3", 32'(bus.red_cur_pos), 32'd3);
    for (int i = 0; i < 41; i++) press(4'b0011, 1'b0);
    check("both_44", 32'({bus.green_cur_pos, bus.red_cur_pos}),
          32'({7'd44, 7'd44}));
    check("not_yet_won", 32'(bus.winner), 32'd0);
    set_btn(4'b0011, 1'b0);
    step();
    check("tie_winner", 32'(bus.winner), 32'b0011);
    check("tie_pos", 32'({bus.green_cur_pos, bus.red_cur_pos}),
          32'({7'd45, 7'd45}));
    check("tie_menu", 32'(bus.is_in_menu), 32'd0);

    n = 0;
    while (bus.is_in_menu == 1'b0 && n < 20) begin
      set_btn((n == 1) ? 4'b0011 : 4'b0000, 1'b0);
      step();
      n++;
      if (n == 3)
        check("frozen", 32'({bus.green_cur_pos, bus.red_cur_pos,
                             bus.winner}),
              32'({7'd45, 7'd45, 4'b0011}));
    end
    check("timeout_cycles", 32'(n), 32'd8);
    check("timeout_clear", 32'({bus.green_cur_pos, bus.red_cur_pos,
                                bus.joined, bus.winner}), 32'd0);

    // Start with no players is ignored, even alongside a join
    set_btn(4'b0000, 1'b1);
    step();
    check("start_empty", 32'({bus.is_in_menu, bus.joined}), 32'b10000);
    set_btn(4'b0000, 1'b0);
    step();
    set_btn(4'b0001, 1'b1);
    step();
    check("join_and_start", 32'({bus.is_in_menu, bus.joined}),
          32'b10001);
    set_btn(4'b0000, 1'b0);
    step();
    press(4'b0000, 1'b1);
    check("solo_start", 32'(bus.is_in_menu), 32'd0);
    for (int i = 0; i < 44; i++) press(4'b0001, 1'b0);
    set_btn(4'b0001, 1'b0);
    step();
    check("solo_win", 32'({bus.is_in_menu, bus.winner,
                           bus.green_cur_pos}),
          32'({1'b0, 4'b0001, 7'd45}));
    set_btn(4'b0000, 1'b0);
    step();
    step();
    check("abort_wait", 32'(bus.is_in_menu), 32'd0);
    set_btn(4'b0000, 1'b1);
    step();
    check("abort_menu", 32'({bus.is_in_menu, bus.green_cur_pos,
                             bus.joined, bus.winner}),
          32'({1'b1, 7'd0, 4'b0, 4'b0}));
    set_btn(4'b0000, 1'b0);
    step();

    // Asynchronous reset mid-race
    press(4'b0001, 1'b0);
    press(4'b0000, 1'b1);
    for (int i = 0; i < 40; i++) press(4'b0001, 1'b0);
    check("mid_40", 32'({bus.is_in_menu, bus.green_cur_pos}),
          32'({1'b0, 7'd40}));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'({bus.is_in_menu, bus.green_cur_pos,
                            bus.joined, bus.winner}),
          32'({1'b1, 7'd0, 4'b0, 4'b0}));
    #2;
    rst_n = 1'b1;
    step();
    check("post_rst", 32'({bus.is_in_menu, bus.green_cur_pos}),
          32'({1'b1, 7'd0}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
